// File: rtl/sha2_pkg.sv
`default_nettype none
// ============================================================================
// Module : sha2_pkg
// Desc   : Command/state encodings and SHA-224/256 initial hash values.
// Rev    : 1.0  initial release
// ============================================================================
package sha2_pkg;

  typedef enum logic [1:0] {
    CMD_INIT  = 2'd0,
    CMD_START = 2'd1,
    CMD_ROUND = 2'd2,
    CMD_FINAL = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_RUN   = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Word 0 (H0) sits in the least significant bits.
  localparam logic [255:0] SHA256_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [255:0] SHA224_IV = {
    32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
    32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8
  };

endpackage
`default_nettype wire

// File: rtl/sha2_word_reg.sv
`default_nettype none
// ============================================================================
// Module : sha2_word_reg
// Desc   : One WORD_W-bit holding register with async reset and load enable.
// Rev    : 1.0  initial release
// ============================================================================
module sha2_word_reg
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] q
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sha256_state_bank.sv
`default_nettype none
// ============================================================================
// Module : sha256_state_bank
// Desc   : SHA-2 working (a..h) and chaining (H0..H7) register bank driven by
//          INIT/START/ROUND/FINAL commands. Option SHA2_STATE_ZEROIZE_EN
//          clears the working registers on FINAL and on an INIT abort.
// Rev    : 1.0  initial release
// ============================================================================
module sha256_state_bank
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64,
  parameter int RW     = $clog2(ROUNDS + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_i,
  input  logic [8*WORD_W-1:0] iv_i,
  input  logic [WORD_W-1:0]   t1_i,
  input  logic [WORD_W-1:0]   t2_i,
  output logic [8*WORD_W-1:0] work_o,
  output logic [8*WORD_W-1:0] hash_o,
  output logic [RW-1:0]       round_o,
  output logic                hash_valid_o,
  input  logic                hash_ready_i,
  output logic                err_o
);

  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS);

  state_e            state;
  state_e            state_next;
  cmd_e              cmd;
  logic [RW-1:0]     round;
  logic [RW-1:0]     round_next;
  logic              err;
  logic              accept;
  logic              legal;
  logic              work_en;
  logic              hash_en;
  logic [WORD_W-1:0] work   [8];
  logic [WORD_W-1:0] work_d [8];
  logic [WORD_W-1:0] hash   [8];
  logic [WORD_W-1:0] hash_d [8];

  assign cmd          = cmd_e'(cmd_i);
  assign cmd_ready_o  = (state != ST_OUT);
  assign accept       = cmd_valid_i && cmd_ready_o;
  assign hash_valid_o = (state == ST_OUT);
  assign round_o      = round;
  assign err_o        = err;

  // INIT is legal in every state that can accept a command at all.
  always_comb begin
    legal = 1'b0;
    case (cmd)
      CMD_INIT:  legal = 1'b1;
      CMD_START: legal = (state == ST_READY);
      CMD_ROUND: legal = (state == ST_RUN) && (round < LAST_ROUND);
      CMD_FINAL: legal = (state == ST_RUN) && (round == LAST_ROUND);
      default:   legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    round_next = round;
    work_en    = 1'b0;
    hash_en    = 1'b0;
    work_d     = work;
    hash_d     = hash;

    if (state == ST_OUT) begin
      if (hash_ready_i) begin
        state_next = ST_READY;
      end
    end else if (accept && legal) begin
      case (cmd)
        CMD_INIT: begin
          work_en    = 1'b1;
          hash_en    = 1'b1;
          round_next = '0;
          state_next = ST_READY;
          for (int i = 0; i < 8; i++) begin
            hash_d[i] = iv_i[i*WORD_W +: WORD_W];
`ifdef SHA2_STATE_ZEROIZE_EN
            work_d[i] = (state == ST_RUN) ? '0 : iv_i[i*WORD_W +: WORD_W];
`else
            work_d[i] = iv_i[i*WORD_W +: WORD_W];
`endif
          end
        end
        CMD_START: begin
          work_en    = 1'b1;
          work_d     = hash;
          round_next = '0;
          state_next = ST_RUN;
        end
        CMD_ROUND: begin
          work_en    = 1'b1;
          round_next = round + RW'(1);
          work_d[0]  = t1_i + t2_i;
          work_d[1]  = work[0];
          work_d[2]  = work[1];
          work_d[3]  = work[2];
          work_d[4]  = work[3] + t1_i;
          work_d[5]  = work[4];
          work_d[6]  = work[5];
          work_d[7]  = work[6];
        end
        CMD_FINAL: begin
          hash_en    = 1'b1;
          state_next = ST_OUT;
          for (int i = 0; i < 8; i++) begin
            hash_d[i] = hash[i] + work[i];
          end
`ifdef SHA2_STATE_ZEROIZE_EN
          work_en = 1'b1;
          for (int i = 0; i < 8; i++) begin
            work_d[i] = '0;
          end
`endif
        end
        default: begin
          state_next = state;
        end
      endcase
    end
  end

  // Commands are never accepted in OUT, so no error can be raised there.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      round <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      round <= round_next;
      err   <= accept && !legal;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_word
    sha2_word_reg #(
      .WORD_W(WORD_W)
    ) u_work (
      .CLK(CLK),
      .RST(RST),
      .en (work_en),
      .d  (work_d[i]),
      .q  (work[i])
    );

    sha2_word_reg #(
      .WORD_W(WORD_W)
    ) u_hash (
      .CLK(CLK),
      .RST(RST),
      .en (hash_en),
      .d  (hash_d[i]),
      .q  (hash[i])
    );

    assign work_o[i*WORD_W +: WORD_W] = work[i];
    assign hash_o[i*WORD_W +: WORD_W] = hash[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_state_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_sha256_state_bank
// Desc   : Self-checking bench for sha256_state_bank (directed + randomized).
// Rev    : 1.0  initial release
// ============================================================================
module tb_sha256_state_bank;
  import sha2_pkg::*;

  localparam int WORD_W = 32;
  localparam int ROUNDS = 64;
  localparam int RW     = $clog2(ROUNDS + 1);
`ifdef SHA2_STATE_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif
  localparam int S_IDLE = 0, S_READY = 1, S_RUN = 2, S_OUT = 3;

  logic                CLK = 1'b0;
  logic                RST;
  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic [1:0]          cmd_i;
  logic [8*WORD_W-1:0] iv_i;
  logic [WORD_W-1:0]   t1_i;
  logic [WORD_W-1:0]   t2_i;
  logic [8*WORD_W-1:0] work_o;
  logic [8*WORD_W-1:0] hash_o;
  logic [RW-1:0]       round_o;
  logic                hash_valid_o;
  logic                hash_ready_i;
  logic                err_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0]  k_tab [64];
  logic [255:0] abc_digest;
  // Expected bank contents for directed tests.
  logic [31:0]  bv [8];
  logic [31:0]  bh [8];
  // Reference model for the randomized test.
  int           m_state;
  int           m_round;
  logic         m_err;
  logic [31:0]  m_work [8];
  logic [31:0]  m_hash [8];

  sha256_state_bank #(
    .WORD_W(WORD_W),
    .ROUNDS(ROUNDS)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_i       (cmd_i),
    .iv_i        (iv_i),
    .t1_i        (t1_i),
    .t2_i        (t2_i),
    .work_o      (work_o),
    .hash_o      (hash_o),
    .round_o     (round_o),
    .hash_valid_o(hash_valid_o),
    .hash_ready_i(hash_ready_i),
    .err_o       (err_o)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] pack8(input logic [31:0] v [8]);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = v[i];
    return r;
  endfunction

  function automatic logic [255:0] rand_iv();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [1:0] c, input logic [31:0] a1, input logic [31:0] a2);
    cmd_valid_i = 1'b1;
    cmd_i       = c;
    t1_i        = a1;
    t2_i        = a2;
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic bank_init(input logic [255:0] iv, input bit aborting);
    iv_i = iv;
    for (int i = 0; i < 8; i++) begin
      bh[i] = iv[32*i +: 32];
      bv[i] = (ZEROIZE && aborting) ? 32'h0 : iv[32*i +: 32];
    end
    send(CMD_INIT, 32'h0, 32'h0);
  endtask

  task automatic bank_start();
    bv = bh;
    send(CMD_START, 32'h0, 32'h0);
  endtask

  task automatic bank_round(input logic [31:0] a1, input logic [31:0] a2);
    for (int i = 7; i > 0; i--) bv[i] = bv[i-1];
    bv[4] = bv[4] + a1;
    bv[0] = a1 + a2;
    send(CMD_ROUND, a1, a2);
  endtask

  task automatic bank_final();
    for (int i = 0; i < 8; i++) begin
      bh[i] = bh[i] + bv[i];
      if (ZEROIZE) bv[i] = 32'h0;
    end
    send(CMD_FINAL, 32'h0, 32'h0);
  endtask

  task automatic model_reset();
    m_state = S_IDLE;
    m_round = 0;
    m_err   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_work[i] = 32'h0;
      m_hash[i] = 32'h0;
    end
  endtask

  // One rising edge of the specified bank behaviour.
  task automatic model_edge(input logic v, input logic [1:0] c, input logic [255:0] iv,
                            input logic [31:0] a1, input logic [31:0] a2, input logic hr);
    logic [31:0] nw [8];
    m_err = 1'b0;
    if (m_state == S_OUT) begin
      if (hr) m_state = S_READY;
    end else if (v) begin
      case (c)
        2'd0: begin
          for (int i = 0; i < 8; i++) begin
            m_hash[i] = iv[32*i +: 32];
            m_work[i] = (ZEROIZE && m_state == S_RUN) ? 32'h0 : iv[32*i +: 32];
          end
          m_round = 0;
          m_state = S_READY;
        end
        2'd1: begin
          if (m_state == S_READY) begin
            m_work  = m_hash;
            m_round = 0;
            m_state = S_RUN;
          end else m_err = 1'b1;
        end
        2'd2: begin
          if (m_state == S_RUN && m_round < ROUNDS) begin
            for (int i = 1; i < 8; i++) nw[i] = m_work[i-1];
            nw[0]   = a1 + a2;
            nw[4]   = m_work[3] + a1;
            m_work  = nw;
            m_round = m_round + 1;
          end else m_err = 1'b1;
        end
        default: begin
          if (m_state == S_RUN && m_round == ROUNDS) begin
            for (int i = 0; i < 8; i++) begin
              m_hash[i] = m_hash[i] + m_work[i];
              if (ZEROIZE) m_work[i] = 32'h0;
            end
            m_state = S_OUT;
          end else m_err = 1'b1;
        end
      endcase
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    vectors++; if (work_o !== 256'h0) begin miscompares++; $display("FAIL reset_work: got %h expected 0", work_o); end
    vectors++; if (hash_o !== 256'h0) begin miscompares++; $display("FAIL reset_hash: got %h expected 0", hash_o); end
    vectors++; if ({round_o, hash_valid_o, err_o, cmd_ready_o} !== {RW'(0), 3'b001}) begin
      miscompares++; $display("FAIL reset_ctrl: got round=%0d hv=%b err=%b rdy=%b expected 0/0/0/1", round_o, hash_valid_o, err_o, cmd_ready_o);
    end
    RST = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin bv[i] = 32'h0; bh[i] = 32'h0; end
  endtask

  task automatic test_init();
    bank_init(SHA256_IV, 1'b0);
    vectors++; if (hash_o !== SHA256_IV) begin miscompares++; $display("FAIL init_hash: got %h expected %h", hash_o, SHA256_IV); end
    vectors++; if (work_o !== SHA256_IV) begin miscompares++; $display("FAIL init_work: got %h expected %h", work_o, SHA256_IV); end
    vectors++; if ({round_o, hash_valid_o, err_o, cmd_ready_o} !== {RW'(0), 3'b001}) begin
      miscompares++; $display("FAIL init_ctrl: got round=%0d hv=%b err=%b rdy=%b expected 0/0/0/1", round_o, hash_valid_o, err_o, cmd_ready_o);
    end
  endtask

  task automatic test_one_round();
    logic [255:0] exp;
    exp = {32'h1f83d9ab, 32'h9b05688c, 32'h510e527f, 32'ha54ff53b,
           32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667, 32'h00000003};
    bank_start();
    vectors++; if (work_o !== SHA256_IV || round_o !== RW'(0)) begin
      miscompares++; $display("FAIL start_work: got %h round %0d expected %h round 0", work_o, round_o, SHA256_IV);
    end
    bank_round(32'd1, 32'd2);
    vectors++; if (work_o !== exp) begin miscompares++; $display("FAIL one_round_work: got %h expected %h", work_o, exp); end
    vectors++; if (round_o !== RW'(1) || err_o !== 1'b0) begin
      miscompares++; $display("FAIL one_round_ctrl: got round=%0d err=%b expected 1/0", round_o, err_o);
    end
  endtask

  task automatic test_abc_block();
    logic [31:0]  w [64];
    logic [31:0]  s0, s1, ch, mj, t1, t2;
    logic [255:0] expw;
    for (int t = 0; t < 16; t++) w[t] = 32'h0;
    w[0]  = 32'h61626380;
    w[15] = 32'h00000018;
    for (int t = 16; t < 64; t++) begin
      s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    bank_init(SHA256_IV, 1'b1);
    bank_start();
    for (int t = 0; t < ROUNDS; t++) begin
      s1 = rotr(bv[4], 6) ^ rotr(bv[4], 11) ^ rotr(bv[4], 25);
      ch = (bv[4] & bv[5]) ^ (~bv[4] & bv[6]);
      t1 = bv[7] + s1 + ch + k_tab[t] + w[t];
      s0 = rotr(bv[0], 2) ^ rotr(bv[0], 13) ^ rotr(bv[0], 22);
      mj = (bv[0] & bv[1]) ^ (bv[0] & bv[2]) ^ (bv[1] & bv[2]);
      t2 = s0 + mj;
      bank_round(t1, t2);
    end
    vectors++; if (round_o !== RW'(ROUNDS) || err_o !== 1'b0) begin
      miscompares++; $display("FAIL abc_rounds: got round=%0d err=%b expected %0d/0", round_o, err_o, ROUNDS);
    end
    bank_final();
    vectors++; if (hash_o !== abc_digest) begin miscompares++; $display("FAIL abc_digest: got %h expected %h", hash_o, abc_digest); end
    expw = pack8(bv);
    vectors++; if (work_o !== expw) begin miscompares++; $display("FAIL abc_work_after_final: got %h expected %h", work_o, expw); end
    vectors++; if (hash_valid_o !== 1'b1 || cmd_ready_o !== 1'b0) begin
      miscompares++; $display("FAIL abc_out_state: got hv=%b rdy=%b expected 1/0", hash_valid_o, cmd_ready_o);
    end
    // Commands offered while the digest is held must be ignored silently.
    cmd_valid_i = 1'b1;
    cmd_i       = CMD_START;
    for (int n = 0; n < 3; n++) begin
      step();
      vectors++; if (hash_valid_o !== 1'b1 || hash_o !== abc_digest || err_o !== 1'b0) begin
        miscompares++; $display("FAIL abc_hold: got hv=%b err=%b hash=%h expected 1/0/%h", hash_valid_o, err_o, hash_o, abc_digest);
      end
    end
    cmd_valid_i  = 1'b0;
    hash_ready_i = 1'b1;
    step();
    hash_ready_i = 1'b0;
    vectors++; if (hash_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL abc_release: got hv=%b rdy=%b expected 0/1", hash_valid_o, cmd_ready_o);
    end
    bank_start();
    vectors++; if (err_o !== 1'b0 || work_o !== abc_digest) begin
      miscompares++; $display("FAIL abc_restart: got err=%b work=%h expected 0/%h", err_o, work_o, abc_digest);
    end
  endtask

  task automatic test_illegal();
    logic [255:0] expw;
    RST = 1'b1;
    step();
    RST = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin bv[i] = 32'h0; bh[i] = 32'h0; end
    send(CMD_START, 32'h0, 32'h0);
    vectors++; if (err_o !== 1'b1 || work_o !== 256'h0 || hash_o !== 256'h0 || round_o !== RW'(0)) begin
      miscompares++; $display("FAIL start_in_idle: got err=%b round=%0d work=%h expected err 1, all zero", err_o, round_o, work_o);
    end
    step();
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL err_pulse_width: got %b expected 0", err_o); end
    bank_init(SHA224_IV, 1'b0);
    bank_start();
    for (int t = 0; t < 10; t++) bank_round($urandom, $urandom);
    send(CMD_FINAL, 32'h0, 32'h0);
    expw = pack8(bv);
    vectors++; if (err_o !== 1'b1 || round_o !== RW'(10) || work_o !== expw || hash_o !== SHA224_IV || hash_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL final_at_10: got err=%b round=%0d hv=%b work=%h expected 1/10/0 work %h", err_o, round_o, hash_valid_o, work_o, expw);
    end
    step();
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL err_after_final_10: got %b expected 0", err_o); end
    for (int t = 10; t < ROUNDS; t++) bank_round($urandom, $urandom);
    send(CMD_ROUND, $urandom, $urandom);
    expw = pack8(bv);
    vectors++; if (err_o !== 1'b1 || round_o !== RW'(ROUNDS) || work_o !== expw) begin
      miscompares++; $display("FAIL round_at_max: got err=%b round=%0d work=%h expected 1/%0d work %h", err_o, round_o, work_o, ROUNDS, expw);
    end
    send(CMD_START, 32'h0, 32'h0);
    vectors++; if (err_o !== 1'b1 || round_o !== RW'(ROUNDS)) begin
      miscompares++; $display("FAIL start_in_run: got err=%b round=%0d expected 1/%0d", err_o, round_o, ROUNDS);
    end
    bank_final();
    expw = pack8(bh);
    vectors++; if (err_o !== 1'b0 || hash_valid_o !== 1'b1 || hash_o !== expw) begin
      miscompares++; $display("FAIL final_legal: got err=%b hv=%b hash=%h expected 0/1/%h", err_o, hash_valid_o, hash_o, expw);
    end
    hash_ready_i = 1'b1;
    step();
    hash_ready_i = 1'b0;
  endtask

  task automatic test_abort();
    logic [255:0] expw;
    bank_init(SHA256_IV, 1'b0);
    bank_start();
    for (int t = 0; t < 30; t++) bank_round($urandom, $urandom);
    bank_init(SHA224_IV, 1'b1);
    expw = ZEROIZE ? 256'h0 : SHA224_IV;
    vectors++; if (hash_o !== SHA224_IV || work_o !== expw) begin
      miscompares++; $display("FAIL abort_regs: got hash=%h work=%h expected %h / %h", hash_o, work_o, SHA224_IV, expw);
    end
    vectors++; if (round_o !== RW'(0) || err_o !== 1'b0) begin
      miscompares++; $display("FAIL abort_ctrl: got round=%0d err=%b expected 0/0", round_o, err_o);
    end
    bank_start();
    vectors++; if (err_o !== 1'b0 || work_o !== SHA224_IV) begin
      miscompares++; $display("FAIL abort_restart: got err=%b work=%h expected 0/%h", err_o, work_o, SHA224_IV);
    end
  endtask

  task automatic test_reset_in_out();
    bank_init(rand_iv(), 1'b1);
    bank_start();
    for (int t = 0; t < ROUNDS; t++) bank_round($urandom, $urandom);
    bank_final();
    vectors++; if (hash_valid_o !== 1'b1) begin miscompares++; $display("FAIL rio_out: got hv=%b expected 1", hash_valid_o); end
    @(negedge CLK);
    RST = 1'b1;
    #1;
    vectors++; if (work_o !== 256'h0 || hash_o !== 256'h0 ||
                   {round_o, hash_valid_o, err_o, cmd_ready_o} !== {RW'(0), 3'b001}) begin
      miscompares++; $display("FAIL rio_async: got round=%0d hv=%b err=%b rdy=%b work=%h hash=%h expected reset values",
                              round_o, hash_valid_o, err_o, cmd_ready_o, work_o, hash_o);
    end
    step();
    RST = 1'b0;
    step();
    send(CMD_START, 32'h0, 32'h0);
    vectors++; if (err_o !== 1'b1 || work_o !== 256'h0) begin
      miscompares++; $display("FAIL rio_start_after_reset: got err=%b work=%h expected 1/0", err_o, work_o);
    end
    step();
  endtask

  task automatic test_random();
    logic         v, hr;
    logic [1:0]   c;
    logic [255:0] iv, ew, eh;
    logic [31:0]  a1, a2;
    int           r;
    RST = 1'b1;
    step();
    RST = 1'b0;
    step();
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      hr = ($urandom_range(0, 3) == 0);
      r  = $urandom_range(0, 99);
      if (m_state == S_RUN && m_round == ROUNDS && r < 60)      c = CMD_FINAL;
      else if (m_state == S_RUN && m_round < ROUNDS && r < 95)  c = CMD_ROUND;
      else if (m_state == S_READY && r < 60)                    c = CMD_START;
      else                                                      c = 2'($urandom_range(0, 3));
      iv = rand_iv();
      a1 = $urandom;
      a2 = $urandom;
      cmd_valid_i  = v;
      cmd_i        = c;
      iv_i         = iv;
      t1_i         = a1;
      t2_i         = a2;
      hash_ready_i = hr;
      step();
      model_edge(v, c, iv, a1, a2, hr);
      ew = pack8(m_work);
      eh = pack8(m_hash);
      vectors++; if (work_o !== ew) begin miscompares++; $display("FAIL rand_work[%0d]: got %h expected %h", n, work_o, ew); end
      vectors++; if (hash_o !== eh) begin miscompares++; $display("FAIL rand_hash[%0d]: got %h expected %h", n, hash_o, eh); end
      vectors++; if (round_o !== RW'(m_round) || err_o !== m_err) begin
        miscompares++; $display("FAIL rand_round_err[%0d]: got round=%0d err=%b expected %0d/%b", n, round_o, err_o, m_round, m_err);
      end
      vectors++; if (hash_valid_o !== (m_state == S_OUT) || cmd_ready_o !== (m_state != S_OUT)) begin
        miscompares++; $display("FAIL rand_hs[%0d]: got hv=%b rdy=%b expected %b/%b", n, hash_valid_o, cmd_ready_o, m_state == S_OUT, m_state != S_OUT);
      end
    end
    cmd_valid_i  = 1'b0;
    hash_ready_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    k_tab = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    abc_digest = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                  32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
    RST          = 1'b1;
    cmd_valid_i  = 1'b0;
    cmd_i        = 2'd0;
    iv_i         = '0;
    t1_i         = '0;
    t2_i         = '0;
    hash_ready_i = 1'b0;

    test_reset();
    test_init();
    test_one_round();
    test_abc_block();
    test_illegal();
    test_abort();
    test_reset_in_out();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
